hams_sdpbram: RTL and testbench

Simple-dual-port synchronous block RAM: one write port and one read port, both on a single clock.
- Generalises the single-port BRAM with byte-enable writes, a configurable read-during-write policy, and a read-valid pipeline.
- Post-reset clear engine zeroes the whole array before the block accepts traffic.
- Used as scratch/bucket storage by the sort and merge datapaths, which need concurrent fill and drain.

---
 rtl/hams_bram_pkg.sv | 34 +++
 rtl/hams_bram_clr_ctrl.sv | 57 +++++
 rtl/hams_sdpbram.sv | 135 +++++++++++++
 tb/tb_hams_sdpbram.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hams_bram_pkg.sv
// Shared types and helpers for the hams simple-dual-port BRAM.
// Parity helpers are only used when HAMS_BRAM_PARITY_EN is defined.
package hams_bram_pkg;

  typedef enum logic {ST_CLEAR, ST_READY} bram_state_e;

  localparam logic RDW_OLD = 1'b0;
  localparam logic RDW_NEW = 1'b1;

  // Helpers work on a wide container; callers cast to their own width.
  localparam int unsigned MAX_W     = 1024;
  localparam int unsigned MAX_BYTES = MAX_W / 8;

  function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0]     old_w,
                                                input logic [MAX_W-1:0]     new_w,
                                                input logic [MAX_BYTES-1:0] be);
    logic [MAX_W-1:0] merged;
    merged = old_w;
    for (int unsigned b = 0; b < MAX_BYTES; b++) begin
      if (be[b]) merged[8*b +: 8] = new_w[8*b +: 8];
    end
    return merged;
  endfunction

  function automatic logic [MAX_BYTES-1:0] byte_parity(input logic [MAX_W-1:0] word);
    logic [MAX_BYTES-1:0] par;
    par = '0;
    for (int unsigned b = 0; b < MAX_BYTES; b++) begin
      par[b] = ^word[8*b +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/hams_bram_clr_ctrl.sv
// Post-reset clear sequencer: walks every address once, then raises init_done.
module hams_bram_clr_ctrl
  import hams_bram_pkg::*;
#(
  parameter int unsigned DATA_DEPTH     = 16,
  parameter logic        CLEAR_ON_RESET = 1'b1,
  parameter int unsigned AW             = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_done
);

  localparam bram_state_e    RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DATA_DEPTH - 1);

  bram_state_e   r_state, w_state_nxt;
  logic [AW-1:0] r_clr_cnt, w_cnt_nxt;
  logic          r_init_done, w_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_STATE;
      r_clr_cnt   <= '0;
      r_init_done <= (RST_STATE == ST_READY);
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_cnt_nxt;
      r_init_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_clr_cnt;
    w_done_nxt  = r_init_done;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt = ST_READY;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      ST_READY: w_done_nxt = 1'b1;
      default:  w_state_nxt = RST_STATE;
    endcase
  end

  assign clr_we    = (r_state == ST_CLEAR);
  assign clr_addr  = r_clr_cnt;
  assign init_done = r_init_done;

endmodule

// File: rtl/hams_sdpbram.sv
// Simple-dual-port BRAM with byte enables, RDW policy, read-valid pipeline and clear engine.
// Optional per-byte even parity under HAMS_BRAM_PARITY_EN.
module hams_sdpbram
  import hams_bram_pkg::*;
#(
  parameter int unsigned DATA_DEPTH       = 16,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter logic        OUT_PIPELINE_ENA = 1'b1,
  parameter logic        RDW_MODE         = 1'b0,
  parameter logic        CLEAR_ON_RESET   = 1'b1,
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8,
  localparam int unsigned AW        = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  wr_en,
  input  logic [NUM_BYTES-1:0]  wr_be,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  input  logic [AW-1:0]         rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_parity_err
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DATA_DEPTH);
  localparam logic        FWD_NEW = (RDW_MODE != RDW_OLD);

  logic                  w_clr_we;
  logic [AW-1:0]         w_clr_addr;
  logic                  w_wr_inr, w_rd_inr, w_usr_we, w_we, w_rd_acc, w_rdw_hit, w_rd_perr;
  logic [AW-1:0]         w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata, w_rd_word, w_rd_merged, w_rd_next;
  logic [NUM_BYTES-1:0]  w_wbe;

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
  logic                  r_v1, r_e1;
  logic [DATA_WIDTH-1:0] r_d1;

  hams_bram_clr_ctrl #(
    .DATA_DEPTH     (DATA_DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .AW             (AW)
  ) u_clr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr),
    .init_done (init_done)
  );

  // The clear engine and the user port share the single physical write port.
  assign w_wr_inr = {1'b0, wr_addr} < DEPTH_L;
  assign w_rd_inr = {1'b0, rd_addr} < DEPTH_L;
  assign w_usr_we = wr_en & init_done & w_wr_inr;
  assign w_we     = w_clr_we | w_usr_we;
  assign w_waddr  = w_clr_we ? w_clr_addr : wr_addr;
  assign w_wdata  = w_clr_we ? '0 : wr_data;
  assign w_wbe    = w_clr_we ? '1 : wr_be;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
        if (w_wbe[b]) r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  assign w_rd_acc    = rd_req & init_done;
  assign w_rd_word   = w_rd_inr ? r_mem[rd_addr] : '0;
  assign w_rdw_hit   = FWD_NEW & w_usr_we & (wr_addr == rd_addr);
  assign w_rd_merged = DATA_WIDTH'(be_merge(MAX_W'(w_rd_word), MAX_W'(wr_data), MAX_BYTES'(wr_be)));
  assign w_rd_next   = w_rdw_hit ? w_rd_merged : w_rd_word;

`ifdef HAMS_BRAM_PARITY_EN
  logic [NUM_BYTES-1:0] r_par [DATA_DEPTH];
  logic [NUM_BYTES-1:0] w_wpar;

  assign w_wpar = NUM_BYTES'(byte_parity(MAX_W'(w_wdata)));

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
        if (w_wbe[b]) r_par[w_waddr][b] <= w_wpar[b];
      end
    end
  end

  // Forwarded words carry fresh parity, so they can never flag an error.
  assign w_rd_perr = ~w_rdw_hit & w_rd_inr &
                     (NUM_BYTES'(byte_parity(MAX_W'(w_rd_word))) != r_par[rd_addr]);
`else
  assign w_rd_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
      r_e1 <= 1'b0;
    end else begin
      r_v1 <= w_rd_acc;
      r_e1 <= w_rd_acc & w_rd_perr;
      if (w_rd_acc) r_d1 <= w_rd_next;
    end
  end

  if (OUT_PIPELINE_ENA) begin : g_pipe
    logic                  r_v2, r_e2;
    logic [DATA_WIDTH-1:0] r_d2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
        r_e2 <= 1'b0;
      end else begin
        r_v2 <= r_v1;
        r_e2 <= r_e1;
        if (r_v1) r_d2 <= r_d1;
      end
    end

    assign rd_valid      = r_v2;
    assign rd_data       = r_d2;
    assign rd_parity_err = r_e2;
  end else begin : g_nopipe
    assign rd_valid      = r_v1;
    assign rd_data       = r_d1;
    assign rd_parity_err = r_e1;
  end

endmodule

// File: tb/tb_hams_sdpbram.sv
// Scoreboard bench for hams_sdpbram: a 16x32 latency-2 old-data instance and a 12x8 latency-1 new-data instance.
module tb_hams_sdpbram;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_wr_en, a_rd_req, a_rd_valid, a_perr, a_init;
  logic [3:0]  a_wr_be, a_wr_addr, a_rd_addr;
  logic [31:0] a_wr_data, a_rd_data;

  logic        b_wr_en, b_rd_req, b_rd_valid, b_perr, b_init;
  logic [0:0]  b_wr_be;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic [7:0]  b_wr_data, b_rd_data;

  hams_sdpbram #(
    .DATA_DEPTH(16), .DATA_WIDTH(32), .OUT_PIPELINE_ENA(1'b1), .RDW_MODE(1'b0), .CLEAR_ON_RESET(1'b1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .init_done(a_init),
    .wr_en(a_wr_en), .wr_be(a_wr_be), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_req(a_rd_req), .rd_addr(a_rd_addr),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_parity_err(a_perr)
  );

  hams_sdpbram #(
    .DATA_DEPTH(12), .DATA_WIDTH(8), .OUT_PIPELINE_ENA(1'b0), .RDW_MODE(1'b1), .CLEAR_ON_RESET(1'b1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .init_done(b_init),
    .wr_en(b_wr_en), .wr_be(b_wr_be), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_req(b_rd_req), .rd_addr(b_rd_addr),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_parity_err(b_perr)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        qa[$], qb[$];
  logic [31:0] ma[16];
  logic [7:0]  mb[12];
  logic [31:0] last_a;
  logic [7:0]  last_b;
  int          n_tests = 0, n_fail = 0, cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("a_rst_vld", {31'b0, a_rd_valid}, 32'd0);
      check("a_rst_data", a_rd_data, 32'd0);
      check("a_rst_init", {31'b0, a_init}, 32'd0);
      check("b_rst_vld", {31'b0, b_rd_valid}, 32'd0);
      check("b_rst_data", {24'b0, b_rd_data}, 32'd0);
      last_a = '0;
      last_b = '0;
    end else begin
      if (qa.size() != 0 && qa[0].cyc == cyc) begin
        e = qa.pop_front();
        check("a_vld", {31'b0, a_rd_valid}, 32'd1);
        check("a_data", a_rd_data, e.data);
        check("a_perr", {31'b0, a_perr}, {31'b0, e.err});
        last_a = e.data;
      end else begin
        check("a_idle_vld", {31'b0, a_rd_valid}, 32'd0);
        check("a_hold", a_rd_data, last_a);
      end
      if (qb.size() != 0 && qb[0].cyc == cyc) begin
        e = qb.pop_front();
        check("b_vld", {31'b0, b_rd_valid}, 32'd1);
        check("b_data", {24'b0, b_rd_data}, e.data);
        check("b_perr", {31'b0, b_perr}, {31'b0, e.err});
        last_b = e.data[7:0];
      end else begin
        check("b_idle_vld", {31'b0, b_rd_valid}, 32'd0);
        check("b_hold", {24'b0, b_rd_data}, {24'b0, last_b});
      end
    end
  end

  task automatic idle_inputs();
    a_wr_en = 0; a_wr_be = '0; a_wr_addr = '0; a_wr_data = '0; a_rd_req = 0; a_rd_addr = '0;
    b_wr_en = 0; b_wr_be = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_req = 0; b_rd_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Latency 2, old data on same-address read/write.
  task automatic opA(input logic we, input logic [3:0] be, input logic [3:0] wa, input logic [31:0] wd,
                     input logic re, input logic [3:0] ra);
    exp_t e;
    a_wr_en = we; a_wr_be = be; a_wr_addr = wa; a_wr_data = wd; a_rd_req = re; a_rd_addr = ra;
    if (re) begin
      e.data = ma[ra]; e.err = 1'b0; e.cyc = cyc + 2;
      qa.push_back(e);
    end
    if (we) ma[wa] = merge32(ma[wa], wd, be);
  endtask

  // Latency 1, new data on same-address read/write, depth 12 (addresses 12..15 out of range).
  task automatic opB(input logic we, input logic be, input logic [3:0] wa, input logic [7:0] wd,
                     input logic re, input logic [3:0] ra);
    exp_t e;
    b_wr_en = we; b_wr_be = be; b_wr_addr = wa; b_wr_data = wd; b_rd_req = re; b_rd_addr = ra;
    if (re) begin
      if (ra < 12) e.data = {24'b0, mb[ra]};
      else         e.data = 32'd0;
      if (we && be && wa == ra && wa < 12) e.data = {24'b0, wd};
      e.err = 1'b0; e.cyc = cyc + 1;
      qb.push_back(e);
    end
    if (we && be && wa < 12) mb[wa] = wd;
  endtask

  task automatic wait_init(output int na, output int nb);
    int n;
    n = 0; na = 0; nb = 0;
    while ((!a_init || !b_init) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (a_init && na == 0) na = n;
      if (b_init && nb == 0) nb = n;
    end
    for (int i = 0; i < 16; i++) ma[i] = '0;
    for (int i = 0; i < 12; i++) mb[i] = '0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      opA(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
      opB(1'b0, 1'b0, 4'h0, 8'h0, 1'b1, 4'(i));
      tick();
    end
    repeat (3) tick();
  endtask

  initial begin
    int na, nb;
    logic [3:0] wa, ra;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();

    rst_n = 1'b1;
    wait_init(na, nb);
    check("a_clear_len", 32'(na), 32'd16);
    check("b_clear_len", 32'(nb), 32'd12);
    read_all();

    opA(1'b1, 4'hF, 4'd3, 32'h000000A5, 1'b0, 4'd0);
    opB(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd0);
    tick();
    opA(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    opB(1'b0, 1'b0, 4'd0, 8'h0, 1'b1, 4'd3);
    tick();
    repeat (3) tick();

    opA(1'b1, 4'hF, 4'd5, 32'h11223344, 1'b0, 4'd0);
    tick();
    opA(1'b1, 4'b0101, 4'd5, 32'hAABBCCDD, 1'b0, 4'd0);
    tick();
    opA(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5);
    tick();
    repeat (3) tick();

    opA(1'b1, 4'hF, 4'd7, 32'h0000005A, 1'b1, 4'd7);
    opB(1'b1, 1'b1, 4'd7, 8'h5A, 1'b1, 4'd7);
    tick();
    opA(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7);
    opB(1'b0, 1'b0, 4'd0, 8'h0, 1'b1, 4'd7);
    tick();
    repeat (3) tick();

    opB(1'b1, 1'b1, 4'd13, 8'hEE, 1'b1, 4'd13);
    tick();
    opB(1'b0, 1'b0, 4'd0, 8'h0, 1'b1, 4'd13);
    tick();
    opB(1'b0, 1'b0, 4'd0, 8'h0, 1'b1, 4'd1);
    tick();

    repeat (120) begin
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      opA(1'($urandom), 4'($urandom), wa, $urandom, 1'($urandom), ra);
      opB(1'($urandom), 1'($urandom_range(0, 7) != 0), wa, 8'($urandom), 1'($urandom), ra);
      tick();
    end
    repeat (4) tick();

`ifdef HAMS_BRAM_PARITY_EN
    begin
      exp_t e;
      opA(1'b1, 4'hF, 4'd2, 32'h12345678, 1'b0, 4'd0);
      tick();
      opA(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2);
      tick();
      repeat (3) tick();
      u_a.r_mem[2][0] = ~u_a.r_mem[2][0];
      ma[2][0] = ~ma[2][0];
      a_rd_req = 1'b1; a_rd_addr = 4'd2;
      e.data = ma[2]; e.err = 1'b1; e.cyc = cyc + 2;
      qa.push_back(e);
      tick();
      repeat (3) tick();
    end
`endif

    opA(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0);
    opB(1'b0, 1'b0, 4'd0, 8'h0, 1'b1, 4'd0);
    tick();
    opA(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd1);
    opB(1'b0, 1'b0, 4'd0, 8'h0, 1'b1, 4'd1);
    tick();
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    check("a_abort_vld", {31'b0, a_rd_valid}, 32'd0);
    check("b_abort_vld", {31'b0, b_rd_valid}, 32'd0);
    repeat (2) tick();

    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_wr_en = 1'b1; a_wr_be = 4'hF; a_wr_addr = 4'd1; a_wr_data = 32'hFFFFFFFF;
      a_rd_req = 1'b1; a_rd_addr = 4'd1;
      b_wr_en = 1'b1; b_wr_be = 1'b1; b_wr_addr = 4'd1; b_wr_data = 8'hFF;
      b_rd_req = 1'b1; b_rd_addr = 4'd1;
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_init(na, nb);
    check("a_reclear_len", 32'(na), 32'd16);
    check("b_reclear_len", 32'(nb), 32'd12);
    read_all();

    check("a_q_empty", 32'(qa.size()), 32'd0);
    check("b_q_empty", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
